// File: rtl/row_by_matrix_mac.sv
// row_by_matrix_mac: one-shot signed row-vector x constant-matrix MAC.
// Captures packed_a once after reset. It then runs IN_D multiply-accumulate
// steps over all OUT_D columns in parallel, and holds the double-width result
// with a sticky out_v.
// Optional build macro: ROW_MATMUL_SATURATE_EN. When it is defined, each
// accumulate step saturates to the signed 2W range. Otherwise accumulation
// wraps in two's complement.
// The weight ROM is taken from WEIGHTS_INIT (entry 0 in the MSBs).
module row_by_matrix_mac #(
  parameter int unsigned W     = 16,
  parameter int unsigned IN_D  = 1,
  parameter int unsigned OUT_D = 1,
  parameter string       WEIGHTS = "",
  parameter logic [IN_D*OUT_D*W-1:0] WEIGHTS_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_D*W-1:0]      packed_a,
  output logic [2*OUT_D*W-1:0]   packed_out,
  output logic                   out_v
);

  localparam int unsigned IDX_W = (IN_D > 1) ? $clog2(IN_D) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_D - 1);

  typedef enum logic [1:0] {
    CAPTURE,
    MAC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]      rom      [IN_D*OUT_D];
  logic [IN_D*W-1:0] a_reg;
  logic [IDX_W-1:0]  idx;
  logic [2*W-1:0]    acc      [OUT_D];
  logic [2*W-1:0]    acc_nxt  [OUT_D];
  logic [W-1:0]      w_sel    [OUT_D];
  logic [2*W-1:0]    prod     [OUT_D];
  logic [2*W:0]      sum      [OUT_D];
  logic [W-1:0]      a_sel;
  logic [2*OUT_D*W-1:0] acc_packed;

  // Weight ROM image, fixed at elaboration
  initial begin
    for (int unsigned k = 0; k < IN_D*OUT_D; k++) begin
      rom[k] = WEIGHTS_INIT[(IN_D*OUT_D-k)*W-1 -: W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CAPTURE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one capture, IN_D MAC steps, then park in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: state_nxt = MAC;
      MAC:     if (idx == IDX_LAST) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = CAPTURE;
    endcase
  end

  // Select input element and weight row for the current index, then form the
  // full-width products and next accumulator values
  always_comb begin
    a_sel = '0;
    for (int unsigned i = 0; i < IN_D; i++) begin
      if (idx == IDX_W'(i)) a_sel = a_reg[(IN_D-i)*W-1 -: W];
    end
    acc_packed = '0;
    for (int unsigned j = 0; j < OUT_D; j++) begin
      w_sel[j] = '0;
      for (int unsigned i = 0; i < IN_D; i++) begin
        if (idx == IDX_W'(i)) w_sel[j] = rom[i*OUT_D+j];
      end
      prod[j] = $signed({{W{a_sel[W-1]}}, a_sel}) *
                $signed({{W{w_sel[j][W-1]}}, w_sel[j]});
      sum[j]  = {acc[j][2*W-1], acc[j]} + {prod[j][2*W-1], prod[j]};
`ifdef ROW_MATMUL_SATURATE_EN
      // The two top bits of the sign-extended sum disagree on overflow.
      if (sum[j][2*W] != sum[j][2*W-1]) begin
        acc_nxt[j] = sum[j][2*W] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
      end else begin
        acc_nxt[j] = sum[j][2*W-1:0];
      end
`else
      acc_nxt[j] = sum[j][2*W-1:0];
`endif
      acc_packed[(OUT_D-j)*2*W-1 -: 2*W] = acc_nxt[j];
    end
  end

  // Datapath registers: input latch, index, accumulators and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg      <= '0;
      idx        <= '0;
      packed_out <= '0;
      out_v      <= 1'b0;
      for (int unsigned j = 0; j < OUT_D; j++) acc[j] <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          a_reg <= packed_a;
          idx   <= '0;
          for (int unsigned j = 0; j < OUT_D; j++) acc[j] <= '0;
        end
        MAC: begin
          for (int unsigned j = 0; j < OUT_D; j++) acc[j] <= acc_nxt[j];
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            packed_out <= acc_packed;
            out_v      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_row_by_matrix_mac.sv
// Scoreboard bench for row_by_matrix_mac.
// Two instances are exercised: a 2x2 basic case and a 4x1 overflow case.
module tb_row_by_matrix_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a_b;
  logic [63:0] a_o;
  logic [63:0] out_b;
  logic [31:0] out_o;
  logic        v_b, v_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [63:0] exp_b_q[$];
  logic [31:0] exp_o_q[$];

  always #5 clk = ~clk;

  row_by_matrix_mac #(
    .W(16), .IN_D(2), .OUT_D(2), .WEIGHTS(""),
    .WEIGHTS_INIT({16'h1000, 16'h2000, 16'hF000, 16'h0800})
  ) dut_b (
    .clk(clk), .rst(rst), .packed_a(a_b), .packed_out(out_b), .out_v(v_b)
  );

  row_by_matrix_mac #(
    .W(16), .IN_D(4), .OUT_D(1), .WEIGHTS(""),
    .WEIGHTS_INIT({4{16'h7FFF}})
  ) dut_o (
    .clk(clk), .rst(rst), .packed_a(a_o), .packed_out(out_o), .out_v(v_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Walk n_edges rising edges after release, popping expectations when out_v rises
  task automatic track(input int unsigned n_edges);
    logic        seen_b, seen_o;
    logic [63:0] hold_b;
    logic [31:0] hold_o;
    seen_b = 1'b0; seen_o = 1'b0; hold_b = '0; hold_o = '0;
    for (int unsigned e = 1; e <= n_edges; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        a_b = 32'h7FFF_7FFF;
        a_o = '0;
      end
      if (!seen_b) begin
        if (v_b) begin
          seen_b = 1'b1;
          check("b_latency", 64'(e), 64'd3);
          if (exp_b_q.size() == 0) check("b_queue", 64'd0, 64'd1);
          else begin
            hold_b = exp_b_q.pop_front();
            check("b_result", out_b, hold_b);
          end
        end else check("b_pre_valid_out", out_b, 64'd0);
      end else begin
        check("b_hold_v", 64'(v_b), 64'd1);
        check("b_hold_out", out_b, hold_b);
      end
      if (!seen_o) begin
        if (v_o) begin
          seen_o = 1'b1;
          check("o_latency", 64'(e), 64'd5);
          if (exp_o_q.size() == 0) check("o_queue", 64'd0, 64'd1);
          else begin
            hold_o = exp_o_q.pop_front();
            check("o_result", 64'(out_o), 64'(hold_o));
          end
        end else check("o_pre_valid_out", 64'(out_o), 64'd0);
      end else begin
        check("o_hold_v", 64'(v_o), 64'd1);
        check("o_hold_out", 64'(out_o), 64'(hold_o));
      end
    end
    if (!seen_b) check("b_timeout", 64'd0, 64'd1);
    if (!seen_o) check("o_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_b_v"},   64'(v_b),   64'd0);
    check({tag, "_b_out"}, out_b,      64'd0);
    check({tag, "_o_v"},   64'(v_o),   64'd0);
    check({tag, "_o_out"}, 64'(out_o), 64'd0);
  endtask

  logic [31:0] exp_ovf;

  initial begin
`ifdef ROW_MATMUL_SATURATE_EN
    exp_ovf = 32'h7FFF_FFFF;
`else
    exp_ovf = 32'hFFFC_0004;
`endif
    // Reset values, clocked while held in reset
    rst = 1'b0;
    a_b = {16'h1000, 16'h2000};
    a_o = {4{16'h7FFF}};
    repeat (2) @(posedge clk);
    #1 check_cleared("in_reset");

    // Basic run with input changed after capture, then 20+ hold cycles
    exp_b_q.push_back(64'hFF00_0000_0300_0000);
    exp_o_q.push_back(exp_ovf);
    @(negedge clk) rst = 1'b1;
    track(26);

    // Asynchronous clear from DONE with nonzero outputs
    @(negedge clk); #2 rst = 1'b0;
    #1 check_cleared("async_done");

    // Reset dropped after the first MAC edge
    a_b = {16'h2000, 16'hF000};
    a_o = {4{16'h7FFF}};
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_cleared("async_mid");

    // Full recompute after re-release
    exp_b_q.push_back(64'h0300_0000_0380_0000);
    exp_o_q.push_back(exp_ovf);
    @(negedge clk) rst = 1'b1;
    track(8);

    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check("o_queue_drained", 64'(exp_o_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
